// File: rtl/lsu_mem_master.sv
// Load/store unit initiator for a word-addressed BRAM port: turns RV32I byte/half/word
// requests into aligned word accesses with strobes and returns one formatted response each.
module lsu_mem_master #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_enable,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic [1:0]            resp_status,
    output logic                  resp_illegal,
    output logic                  mem_r_en,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [31:0]           mem_r_data,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [31:0]           mem_w_data,
    output logic [3:0]            mem_w_strb,
    input  logic [1:0]            mem_state
);

    localparam logic [1:0] MEMORY_STATE_SUCCESS       = 2'b00;
    localparam logic [1:0] MEMORY_STATE_OUT_OF_BOUNDS = 2'b01;
    localparam logic [1:0] MEMORY_STATE_READ_WRITE    = 2'b10;
    localparam logic [1:0] MEMORY_STATE_ALIGNMENT     = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CHECK = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [1:0]            r_addr_lo;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [31:0]           r_resp_rdata;
    logic [1:0]            r_resp_status;
    logic                  r_resp_illegal;
    logic                  r_mem_r_en;
    logic                  r_mem_w_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_w_data;
    logic [3:0]            r_mem_w_strb;

    logic                  w_legal;
    logic                  w_misaligned;
    logic [ADDR_WIDTH-1:0] w_word_addr;

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] r);
        logic [31:0] v_byte;
        logic [31:0] v_half;
        v_byte = r >> {a, 3'b000};
        v_half = r >> {a[1], 4'b0000};
        case (f3)
            3'b000:  return {{24{v_byte[7]}}, v_byte[7:0]};
            3'b001:  return {{16{v_half[15]}}, v_half[15:0]};
            3'b100:  return {24'd0, v_byte[7:0]};
            3'b101:  return {16'd0, v_half[15:0]};
            default: return r;
        endcase
    endfunction

    assign w_legal      = is_legal(req_we, req_funct3);
    assign w_misaligned = is_misaligned(req_funct3, req_addr[1:0]);
    assign w_word_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_we           <= 1'b0;
            r_funct3       <= 3'd0;
            r_addr_lo      <= 2'd0;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= 32'd0;
            r_resp_status  <= MEMORY_STATE_SUCCESS;
            r_resp_illegal <= 1'b0;
            r_mem_r_en     <= 1'b0;
            r_mem_w_en     <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_w_data   <= 32'd0;
            r_mem_w_strb   <= 4'd0;
        end else if (clk_enable) begin
            case (r_state)
                // accept: local errors go straight to RESP without touching memory
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_funct3    <= req_funct3;
                        r_addr_lo   <= req_addr[1:0];
                        r_req_ready <= 1'b0;
                        if (!w_legal || w_misaligned) begin
                            r_resp_illegal <= !w_legal;
                            r_resp_status  <= w_legal ? MEMORY_STATE_ALIGNMENT
                                                      : MEMORY_STATE_SUCCESS;
                            r_resp_rdata   <= 32'd0;
                            r_resp_valid   <= 1'b1;
                            r_state        <= S_RESP;
                        end else begin
                            r_resp_illegal <= 1'b0;
                            r_mem_addr     <= w_word_addr;
                            r_mem_r_en     <= !req_we;
                            r_mem_w_en     <= req_we;
                            if (req_we) begin
                                r_mem_w_data <= store_data(req_funct3, req_wdata);
                                r_mem_w_strb <= store_strb(req_funct3, req_addr[1:0]);
                            end
                            r_state <= S_ISSUE;
                        end
                    end
                end
                // memory samples the enable at the end of this cycle
                S_ISSUE: begin
                    r_mem_r_en <= 1'b0;
                    r_mem_w_en <= 1'b0;
                    r_state    <= S_CHECK;
                end
                // memory result is valid now
                S_CHECK: begin
                    r_resp_status <= mem_state;
                    r_resp_rdata  <= (r_we || mem_state != MEMORY_STATE_SUCCESS) ? 32'd0
                                     : load_format(r_funct3, r_addr_lo, mem_r_data);
                    r_resp_valid  <= 1'b1;
                    r_state       <= S_RESP;
                end
                // hold response until consumed
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign resp_status  = r_resp_status;
    assign resp_illegal = r_resp_illegal;
    assign mem_r_en     = r_mem_r_en;
    assign mem_w_en     = r_mem_w_en;
    assign mem_r_addr   = r_mem_addr;
    assign mem_w_addr   = r_mem_addr;
    assign mem_w_data   = r_mem_w_data;
    assign mem_w_strb   = r_mem_w_strb;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: 1024-word BRAM model, directed requests, queue-based response scoreboard.
module tb_lsu_mem_master;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_OOB   = 2'b01;
    localparam logic [1:0] ST_ALIGN = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_enable = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_status;
    logic        resp_illegal;
    logic        mem_r_en;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_r_data;
    logic        mem_w_en;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_w_data;
    logic [3:0]  mem_w_strb;
    logic [1:0]  mem_state;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  status;
        logic        illegal;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_status(resp_status), .resp_illegal(resp_illegal),
        .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
        .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_w_strb(mem_w_strb), .mem_state(mem_state)
    );

    // Memory model: one-cycle registered read, strobed write, out of range -> OUT_OF_BOUNDS.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem_r_data = 32'd0;
        mem_state  = ST_OK;
    end

    always @(posedge clk) begin
        if (mem_r_en) begin
            if (mem_r_addr[31:2] >= 30'd1024) begin
                mem_state  <= ST_OOB;
                mem_r_data <= 32'hA5A5A5A5;
            end else begin
                mem_state  <= ST_OK;
                mem_r_data <= mem[mem_r_addr[11:2]];
            end
        end
        if (mem_w_en) begin
            if (mem_w_addr[31:2] >= 30'd1024) begin
                mem_state <= ST_OOB;
            end else begin
                mem_state <= ST_OK;
                for (int b = 0; b < 4; b++)
                    if (mem_w_strb[b]) mem[mem_w_addr[11:2]][b*8 +: 8] <= mem_w_data[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    // Monitor: a response is consumed on the edge following this negedge.
    always @(negedge clk) begin
        if (rst_n && clk_enable && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_response", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_status", {30'd0, resp_status}, {30'd0, e.status});
                chk("resp_illegal", {31'd0, resp_illegal}, {31'd0, e.illegal});
            end
        end
    end

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
        int g;
        g = 0;
        @(negedge clk);
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_req(input string nm, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] e_rd, input logic [1:0] e_st, input logic e_il,
                          input int e_lat, input logic [3:0] e_strb, input logic [31:0] e_wd);
        int lat, en_cnt, both;
        logic c_w, c_r;
        logic [3:0] c_strb;
        logic [31:0] c_wd, c_wa, c_ra;
        exp_q.push_back('{rdata: e_rd, status: e_st, illegal: e_il});
        drive_req(we, f3, a, wd);
        c_w = mem_w_en; c_r = mem_r_en; c_strb = mem_w_strb;
        c_wd = mem_w_data; c_wa = mem_w_addr; c_ra = mem_r_addr;
        lat = 0; en_cnt = 0; both = 0;
        while (!resp_valid && lat < 20) begin
            if (mem_r_en || mem_w_en) en_cnt++;
            if (mem_r_en && mem_w_en) both++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, e_lat);
        chk({nm, "_enable_cycles"}, en_cnt, (e_lat == 2) ? 1 : 0);
        chk({nm, "_both_enables"}, both, 0);
        if (e_lat == 2 && we) begin
            chk({nm, "_w_en"}, {31'd0, c_w}, 32'd1);
            chk({nm, "_w_strb"}, {28'd0, c_strb}, {28'd0, e_strb});
            chk({nm, "_w_data"}, c_wd, e_wd);
            chk({nm, "_w_addr"}, c_wa, {a[31:2], 2'b00});
        end else if (e_lat == 2) begin
            chk({nm, "_r_en"}, {31'd0, c_r}, 32'd1);
            chk({nm, "_r_addr"}, c_ra, {a[31:2], 2'b00});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_enables", {30'd0, mem_r_en, mem_w_en}, 32'd0);
        chk("rst_resp_status", {30'd0, resp_status}, 32'd0);
        chk("rst_w_strb", {28'd0, mem_w_strb}, 32'd0);
        rst_n = 1'b1;

        do_req("SW",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0,        ST_OK, 1'b0, 2, 4'b1111, 32'hDEADBEEF);
        do_req("LW",  1'b0, 3'b010, 32'h10, 32'd0,        32'hDEADBEEF, ST_OK, 1'b0, 2, 4'd0, 32'd0);
        do_req("SB",  1'b1, 3'b000, 32'h13, 32'h00000080, 32'd0,        ST_OK, 1'b0, 2, 4'b1000, 32'h80808080);
        do_req("LB",  1'b0, 3'b000, 32'h13, 32'd0,        32'hFFFFFF80, ST_OK, 1'b0, 2, 4'd0, 32'd0);
        do_req("LBU", 1'b0, 3'b100, 32'h13, 32'd0,        32'h00000080, ST_OK, 1'b0, 2, 4'd0, 32'd0);
        do_req("SH",  1'b1, 3'b001, 32'h12, 32'h55661234, 32'd0,        ST_OK, 1'b0, 2, 4'b1100, 32'h12341234);
        do_req("LH",  1'b0, 3'b001, 32'h12, 32'd0,        32'h00001234, ST_OK, 1'b0, 2, 4'd0, 32'd0);
        do_req("LHU", 1'b0, 3'b101, 32'h10, 32'd0,        32'h0000BEEF, ST_OK, 1'b0, 2, 4'd0, 32'd0);
        do_req("LHs", 1'b0, 3'b001, 32'h10, 32'd0,        32'hFFFFBEEF, ST_OK, 1'b0, 2, 4'd0, 32'd0);
        do_req("LHmis", 1'b0, 3'b001, 32'h11, 32'd0,      32'd0,        ST_ALIGN, 1'b0, 0, 4'd0, 32'd0);
        do_req("SWmis", 1'b1, 3'b010, 32'h12, 32'h1,      32'd0,        ST_ALIGN, 1'b0, 0, 4'd0, 32'd0);
        do_req("LWoob", 1'b0, 3'b010, 32'h1000, 32'd0,    32'd0,        ST_OOB, 1'b0, 2, 4'd0, 32'd0);
        do_req("LDill", 1'b0, 3'b011, 32'h10, 32'd0,      32'd0,        ST_OK, 1'b1, 0, 4'd0, 32'd0);
        do_req("STill", 1'b1, 3'b100, 32'h10, 32'h7,      32'd0,        ST_OK, 1'b1, 0, 4'd0, 32'd0);

        // Freeze during ISSUE and back-pressure the response.
        resp_ready = 1'b0;
        exp_q.push_back('{rdata: 32'h1234BEEF, status: ST_OK, illegal: 1'b0});
        drive_req(1'b0, 3'b010, 32'h10, 32'd0);
        clk_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("frz_r_en", {31'd0, mem_r_en}, 32'd1);
        chk("frz_req_ready", {31'd0, req_ready}, 32'd0);
        chk("frz_resp_valid", {31'd0, resp_valid}, 32'd0);
        clk_enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("stall_rdata", resp_rdata, 32'h1234BEEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, 32'h1234BEEF);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("after_hold_req_ready", {31'd0, req_ready}, 32'd1);

        // Reset while in CHECK: request is dropped without a response.
        drive_req(1'b0, 3'b010, 32'h10, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_enables", {30'd0, mem_r_en, mem_w_en}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_stale_resp", {31'd0, resp_valid}, 32'd0);

        do_req("LWpost", 1'b0, 3'b010, 32'h10, 32'd0, 32'h1234BEEF, ST_OK, 1'b0, 2, 4'd0, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
